// File: rtl/store_align_unit_pkg.sv
// ----------------------------------------------------------------------------
// store_align_unit_pkg : shared types for the store alignment unit
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package store_align_unit_pkg;

  // log2 of the access size in bytes
  typedef logic [2:0] msize_t;

  localparam msize_t MSIZE1  = 3'd0;
  localparam msize_t MSIZE2  = 3'd1;
  localparam msize_t MSIZE4  = 3'd2;
  localparam msize_t MSIZE8  = 3'd3;
  localparam msize_t MSIZE16 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } align_state_t;

endpackage

`default_nettype wire

// File: rtl/store_align_unit_lane_shift.sv
// ----------------------------------------------------------------------------
// store_align_unit_lane_shift : places a store into a double-width lane window
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module store_align_unit_lane_shift
  import store_align_unit_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int MISALIGN_MODE = 1,
  parameter int NB            = DATA_W / 8,
  parameter int OFF_W         = $clog2(NB)
) (
  input  logic [OFF_W-1:0]    i_off,
  input  msize_t              i_msize,
  input  logic [DATA_W-1:0]   i_data,
  output logic [2*DATA_W-1:0] o_wide_data,
  output logic [2*NB-1:0]     o_wide_strb,
  output logic                o_cross,
  output logic                o_err
);

  logic [8:0]        w_n;
  logic [NB-1:0]     w_lane_en;
  logic [DATA_W-1:0] w_data_m;
  logic [15:0]       w_end;

  assign w_n = 9'd1 << i_msize;

  // Bytes above the access size are dropped before shifting
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign w_lane_en[i]       = (9'(i) < w_n);
    assign w_data_m[8*i +: 8] = i_data[8*i +: 8] & {8{w_lane_en[i]}};
  end

  assign o_wide_data = {{DATA_W{1'b0}}, w_data_m} << {i_off, 3'b000};
  assign o_wide_strb = {{NB{1'b0}}, w_lane_en} << i_off;

  assign w_end   = 16'(i_off) + 16'(w_n);
  assign o_cross = (w_end > 16'(NB));
  assign o_err   = (16'(w_n) > 16'(NB)) ||
                   ((MISALIGN_MODE == 0) &&
                    ((16'(i_off) & (16'(w_n) - 16'd1)) != 16'd0));

endmodule

`default_nettype wire

// File: rtl/store_align_unit.sv
// ----------------------------------------------------------------------------
// store_align_unit : byte-lane store aligner with optional two-beat split
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int ADDR_W        = 64,
  parameter int MISALIGN_MODE = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  msize_t              req_msize,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_data,
  output logic [DATA_W/8-1:0] bus_strobe,
  output logic                resp_valid,
  output logic                resp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef logic [NB-1:0] strb_t;

  logic [2*DATA_W-1:0] w_wide_data;
  logic [2*NB-1:0]     w_wide_strb;
  logic                w_cross;
  logic                w_err;

  align_state_t        r_state;
  logic                r_bus_valid;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_data;
  strb_t               r_bus_strobe;
  logic [DATA_W-1:0]   r_hi_data;
  strb_t               r_hi_strb;
  logic                r_cross;
  logic                r_resp_valid;
  logic                r_resp_err;

  store_align_unit_lane_shift #(
    .DATA_W       (DATA_W),
    .MISALIGN_MODE(MISALIGN_MODE),
    .NB           (NB),
    .OFF_W        (OFF_W)
  ) u_lane_shift (
    .i_off      (req_addr[OFF_W-1:0]),
    .i_msize    (req_msize),
    .i_data     (req_data),
    .o_wide_data(w_wide_data),
    .o_wide_strb(w_wide_strb),
    .o_cross    (w_cross),
    .o_err      (w_err)
  );

  assign req_ready  = (r_state == ST_IDLE);
  assign bus_valid  = r_bus_valid;
  assign bus_addr   = r_bus_addr;
  assign bus_data   = r_bus_data;
  assign bus_strobe = r_bus_strobe;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_bus_valid  <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_data   <= '0;
      r_bus_strobe <= '0;
      r_hi_data    <= '0;
      r_hi_strb    <= '0;
      r_cross      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          if (req_valid) begin
            if (w_err) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_state      <= ST_BEAT0;
              r_bus_valid  <= 1'b1;
              r_bus_addr   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              r_bus_data   <= w_wide_data[DATA_W-1:0];
              r_bus_strobe <= w_wide_strb[NB-1:0];
              r_hi_data    <= w_wide_data[2*DATA_W-1:DATA_W];
              r_hi_strb    <= w_wide_strb[2*NB-1:NB];
              r_cross      <= w_cross;
            end
          end
        end
        ST_BEAT0: begin
          if (bus_ready) begin
            if (r_cross) begin
              // Second beat wraps naturally at the top of the address space
              r_state      <= ST_BEAT1;
              r_bus_addr   <= r_bus_addr + ADDR_W'(NB);
              r_bus_data   <= r_hi_data;
              r_bus_strobe <= r_hi_strb;
            end else begin
              r_state      <= ST_RESP;
              r_bus_valid  <= 1'b0;
              r_resp_valid <= 1'b1;
            end
          end
        end
        ST_BEAT1: begin
          if (bus_ready) begin
            r_state      <= ST_RESP;
            r_bus_valid  <= 1'b0;
            r_resp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_align_unit.sv
// ----------------------------------------------------------------------------
// tb_store_align_unit : directed scoreboard bench for store_align_unit
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_store_align_unit;
  import store_align_unit_pkg::*;

  typedef struct {
    int          inst;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } beat_t;

  typedef struct {
    int   inst;
    logic err;
  } resp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        bus_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  msize_t      req_msize;
  logic        rq_v [3];

  // per-instance outputs: a = 64b mode1, b = 64b mode0, c = 32b mode1
  logic        a_rr, b_rr, c_rr, a_bv, b_bv, c_bv, a_rv, b_rv, c_rv, a_re, b_re, c_re;
  logic [63:0] a_ba, b_ba, c_ba, a_bd, b_bd;
  logic [31:0] c_bd;
  logic [7:0]  a_bs, b_bs;
  logic [3:0]  c_bs;

  logic        rr [3];
  logic        bv [3];
  logic        rv [3];
  logic        re [3];
  logic [63:0] ba [3];
  logic [63:0] bd [3];
  logic [7:0]  bs [3];

  beat_t qb[$];
  resp_t qr[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  store_align_unit #(.DATA_W(64), .ADDR_W(64), .MISALIGN_MODE(1)) u_dut_a (
    .clk(clk), .resetn(resetn), .req_valid(rq_v[0]), .req_ready(a_rr),
    .req_addr(req_addr), .req_data(req_data), .req_msize(req_msize),
    .bus_valid(a_bv), .bus_ready(bus_ready), .bus_addr(a_ba), .bus_data(a_bd),
    .bus_strobe(a_bs), .resp_valid(a_rv), .resp_err(a_re));

  store_align_unit #(.DATA_W(64), .ADDR_W(64), .MISALIGN_MODE(0)) u_dut_b (
    .clk(clk), .resetn(resetn), .req_valid(rq_v[1]), .req_ready(b_rr),
    .req_addr(req_addr), .req_data(req_data), .req_msize(req_msize),
    .bus_valid(b_bv), .bus_ready(bus_ready), .bus_addr(b_ba), .bus_data(b_bd),
    .bus_strobe(b_bs), .resp_valid(b_rv), .resp_err(b_re));

  store_align_unit #(.DATA_W(32), .ADDR_W(64), .MISALIGN_MODE(1)) u_dut_c (
    .clk(clk), .resetn(resetn), .req_valid(rq_v[2]), .req_ready(c_rr),
    .req_addr(req_addr), .req_data(req_data[31:0]), .req_msize(req_msize),
    .bus_valid(c_bv), .bus_ready(bus_ready), .bus_addr(c_ba), .bus_data(c_bd),
    .bus_strobe(c_bs), .resp_valid(c_rv), .resp_err(c_re));

  always_comb begin
    rr[0] = a_rr; rr[1] = b_rr; rr[2] = c_rr;
    bv[0] = a_bv; bv[1] = b_bv; bv[2] = c_bv;
    rv[0] = a_rv; rv[1] = b_rv; rv[2] = c_rv;
    re[0] = a_re; re[1] = b_re; re[2] = c_re;
    ba[0] = a_ba; ba[1] = b_ba; ba[2] = c_ba;
    bd[0] = a_bd; bd[1] = b_bd; bd[2] = 64'(c_bd);
    bs[0] = a_bs; bs[1] = b_bs; bs[2] = 8'(c_bs);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input int inst, input logic [63:0] addr,
                           input logic [63:0] data, input logic [7:0] strb);
    beat_t e;
    e.inst = inst; e.addr = addr; e.data = data; e.strb = strb;
    qb.push_back(e);
  endtask

  task automatic push_resp(input int inst, input logic err);
    resp_t e;
    e.inst = inst; e.err = err;
    qr.push_back(e);
  endtask

  task automatic issue(input int inst, input logic [63:0] addr,
                       input logic [63:0] data, input msize_t m);
    req_addr    = addr;
    req_data    = data;
    req_msize   = m;
    rq_v[inst]  = 1'b1;
    tick();
    rq_v[inst]  = 1'b0;
  endtask

  task automatic wait_idle(input int inst);
    for (int k = 0; k < 20 && rr[inst] !== 1'b1; k++) tick();
    check("idle_timeout", 64'(rr[inst]), 64'd1);
  endtask

  // Scoreboard: every accepted beat and every response pops one expectation
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      for (int i = 0; i < 3; i++) begin
        if (bv[i] === 1'b1) check("strobe_nonzero", 64'(bs[i] != 8'd0), 64'd1);
        if (bv[i] === 1'b1 && bus_ready === 1'b1) begin
          check("beat_expected", 64'(qb.size() != 0), 64'd1);
          if (qb.size() != 0) begin
            beat_t e;
            e = qb.pop_front();
            check("beat_inst", 64'(i), 64'(e.inst));
            check("beat_addr", ba[i], e.addr);
            check("beat_data", bd[i], e.data);
            check("beat_strobe", 64'(bs[i]), 64'(e.strb));
          end
        end
        if (rv[i] === 1'b1) begin
          check("resp_expected", 64'(qr.size() != 0), 64'd1);
          if (qr.size() != 0) begin
            resp_t r;
            r = qr.pop_front();
            check("resp_inst", 64'(i), 64'(r.inst));
            check("resp_err", 64'(re[i]), 64'(r.err));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    bus_ready = 1'b1;
    req_addr  = '0;
    req_data  = '0;
    req_msize = MSIZE1;
    for (int i = 0; i < 3; i++) rq_v[i] = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 3; i++) begin
      check("rst_req_ready", 64'(rr[i]), 64'd1);
      check("rst_bus_valid", 64'(bv[i]), 64'd0);
      check("rst_resp_valid", 64'(rv[i]), 64'd0);
      check("rst_resp_err", 64'(re[i]), 64'd0);
      check("rst_bus_addr", ba[i], 64'd0);
      check("rst_bus_data", bd[i], 64'd0);
      check("rst_bus_strobe", 64'(bs[i]), 64'd0);
    end
    resetn = 1'b1;
    tick();

    // sb, byte 3: upper data bits must be masked off
    push_beat(0, 64'h1000, 64'h0000_0000_AB00_0000, 8'h08);
    push_resp(0, 1'b0);
    issue(0, 64'h1003, 64'h5555_5555_5555_55AB, MSIZE1);
    check("sb_bv_at_1", 64'(bv[0]), 64'd1);
    check("sb_ready_busy", 64'(rr[0]), 64'd0);
    tick();
    check("sb_resp_at_2", 64'(rv[0]), 64'd1);
    tick();
    check("sb_resp_drop", 64'(rv[0]), 64'd0);
    check("sb_ready_back", 64'(rr[0]), 64'd1);

    // sw crossing the 8-byte boundary: split into two beats
    push_beat(0, 64'h1000, 64'h3344_0000_0000_0000, 8'hC0);
    push_beat(0, 64'h1008, 64'h0000_0000_0000_1122, 8'h03);
    push_resp(0, 1'b0);
    issue(0, 64'h1006, 64'h0000_0000_1122_3344, MSIZE4);
    check("split_bv_at_1", 64'(bv[0]), 64'd1);
    tick();
    check("split_bv_beat1", 64'(bv[0]), 64'd1);
    check("split_no_early_resp", 64'(rv[0]), 64'd0);
    tick();
    check("split_resp_at_3", 64'(rv[0]), 64'd1);
    wait_idle(0);

    // same sw with strict alignment is rejected without any bus beat
    push_resp(1, 1'b1);
    issue(1, 64'h1006, 64'h0000_0000_1122_3344, MSIZE4);
    check("err_resp_at_1", 64'(rv[1]), 64'd1);
    check("err_flag", 64'(re[1]), 64'd1);
    check("err_no_bus", 64'(bv[1]), 64'd0);
    tick();
    check("err_resp_one_cycle", 64'(rv[1]), 64'd0);
    wait_idle(1);

    // sd with bus stalled for 5 cycles
    bus_ready = 1'b0;
    push_beat(0, 64'h2000, 64'h0123_4567_89AB_CDEF, 8'hFF);
    push_resp(0, 1'b0);
    issue(0, 64'h2000, 64'h0123_4567_89AB_CDEF, MSIZE8);
    for (int k = 0; k < 5; k++) begin
      check("stall_bv", 64'(bv[0]), 64'd1);
      check("stall_ready", 64'(rr[0]), 64'd0);
      check("stall_addr", ba[0], 64'h2000);
      check("stall_data", bd[0], 64'h0123_4567_89AB_CDEF);
      check("stall_strobe", 64'(bs[0]), 64'hFF);
      check("stall_no_resp", 64'(rv[0]), 64'd0);
      tick();
    end
    bus_ready = 1'b1;
    tick();
    check("stall_resp", 64'(rv[0]), 64'd1);
    check("stall_bv_drop", 64'(bv[0]), 64'd0);
    tick();
    check("stall_resp_one_cycle", 64'(rv[0]), 64'd0);
    wait_idle(0);

    // reset while the second beat of a split store is pending
    push_beat(0, 64'h1000, 64'h3344_0000_0000_0000, 8'hC0);
    issue(0, 64'h1006, 64'h0000_0000_1122_3344, MSIZE4);
    tick();
    check("abort_in_beat1", ba[0], 64'h1008);
    bus_ready = 1'b0;
    resetn    = 1'b0;
    tick();
    check("abort_bv", 64'(bv[0]), 64'd0);
    check("abort_ready", 64'(rr[0]), 64'd1);
    resetn    = 1'b1;
    bus_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("abort_no_resp", 64'(rv[0]), 64'd0);
      tick();
    end

    // 32-bit bus: 8-byte store is an error
    push_resp(2, 1'b1);
    issue(2, 64'h3000, 64'h1111_2222_3333_4444, MSIZE8);
    check("c_err_at_1", 64'(rv[2]), 64'd1);
    check("c_err_flag", 64'(re[2]), 64'd1);
    wait_idle(2);

    // 32-bit bus: full-width aligned store passes straight through
    push_beat(2, 64'h4000, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    push_resp(2, 1'b0);
    issue(2, 64'h4000, 64'hFFFF_FFFF_DEAD_BEEF, MSIZE4);
    wait_idle(2);

    // sh at the last byte of the address space wraps beat 1 to zero
    push_beat(0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hEF00_0000_0000_0000, 8'h80);
    push_beat(0, 64'h0, 64'h0000_0000_0000_00BE, 8'h01);
    push_resp(0, 1'b0);
    issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_BEEF, MSIZE2);
    wait_idle(0);
    tick();

    check("beats_drained", 64'(qb.size()), 64'd0);
    check("resps_drained", 64'(qr.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
